// File: rtl/uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend
//   Serial receive front-end for tt_um_cejmu. Synchronises the raw RX pin,
//   deserialises 8N1 frames and hands each byte to the core datapath over a
//   valid/ready handshake, with one-cycle framing-error and overrun pulses.
//
//   Optional feature macro: CEJMU_RX_PARITY_EN
//     undefined (default) : 8N1 framing, no parity state or logic.
//     defined             : 8O1 framing; a parity bit follows the data bits
//                           and odd-parity violations are reported as
//                           framing errors.
//
//   The enclosing top level drives rst from rst_n inverted and passes ena
//   straight through.
// ---------------------------------------------------------------------------
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  // Baud counter is just wide enough for the largest reload value.
  localparam int CW = $clog2(CLKS_PER_BIT);

  // First sample lands roughly mid start bit; later samples one bit apart.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  // FSM encoding kept as plain constants for compatibility with older flows.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef CEJMU_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  // Reject out-of-range configurations at elaboration time.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 4095) begin : g_bad_clks_per_bit
    $error("uart_rx_frontend: CLKS_PER_BIT must be in 4..4095");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("uart_rx_frontend: SYNC_STAGES must be in 2..3");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;

  logic baud_zero;
  logic stop_sample;
  logic parity_ok;
  logic byte_good;
  logic frame_bad;

`ifdef CEJMU_RX_PARITY_EN
  logic par_bad_q;
`endif

  // Input synchroniser: shifts the asynchronous pin toward rxs, idle high.
  always_ff @(posedge clk) begin
    // NOTE: state in clocked blocks uses non-blocking (<=) so every flop
    // samples pre-edge values; blocking here would collapse the shift chain.
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Stop-bit decision: classify the completing frame as good or bad.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    baud_zero   = (baud_cnt == '0);
    stop_sample = 1'b0;
    parity_ok   = 1'b1;
    byte_good   = 1'b0;
    frame_bad   = 1'b0;
`ifdef CEJMU_RX_PARITY_EN
    parity_ok   = !par_bad_q;
`endif
    // ena low aborts the frame, so a stop sample only counts while enabled.
    stop_sample = ena && (state == S_STOP) && baud_zero;
    byte_good   = stop_sample && rxs && parity_ok;
    frame_bad   = stop_sample && !(rxs && parity_ok);
  end

  // Receive FSM: start validation, bit timing and LSB-first deserialising.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      // NOTE: the shift register is a small datapath register, not a memory
      // array, so it is reset too; simulation then never starts from X.
      shift_q  <= '0;
`ifdef CEJMU_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else if (!ena) begin
      // Abort: back to IDLE with cleared counters, no flags for this frame.
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state    <= S_START;
            baud_cnt <= HALF_LOAD;
          end
        end

        S_START: begin
          if (baud_zero) begin
            if (rxs) begin
              // Line high again mid start bit: a glitch, not a frame.
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              baud_cnt <= BIT_LOAD;
              bit_cnt  <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end

        S_DATA: begin
          if (baud_zero) begin
            shift_q  <= {rxs, shift_q[7:1]};
            baud_cnt <= BIT_LOAD;
            if (bit_cnt == 3'd7) begin
`ifdef CEJMU_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end

`ifdef CEJMU_RX_PARITY_EN
        S_PARITY: begin
          if (baud_zero) begin
            // Odd parity: data bits XOR parity bit must be 1.
            par_bad_q <= ~(^shift_q ^ rxs);
            baud_cnt  <= BIT_LOAD;
            state     <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (baud_zero) begin
            // A low stop bit may be a break: wait for the line to recover.
            state <= rxs ? S_IDLE : S_WAIT_HIGH;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end

        S_WAIT_HIGH: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Holding register, handshake and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_bad;
      // Consumption in the same cycle frees the register, so no overrun.
      overrun_o   <= byte_good && valid_o && !ready_i;
      if (byte_good && (!valid_o || ready_i)) begin
        data_o  <= shift_q;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frontend
//   Directed bench for uart_rx_frontend at CLKS_PER_BIT = 8, SYNC_STAGES = 2.
//   Bytes expected to reach the core are queued when their frame is driven
//   and popped when the DUT hands a byte over (valid_o && ready_i).
//   Parity scenarios are compiled in when CEJMU_RX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int CPB = 8;
`ifdef CEJMU_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Busy from start detection to the stop sample: half-bit start check plus
  // one full bit per remaining frame bit.
  localparam int BUSY_CYCLES = CPB / 2 + 1 + CPB * (FRAME_BITS - 1);

  logic       clk;
  logic       rst;
  logic       ena;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Event counters maintained by the monitor.
  int n_pop       = 0;
  int n_valid_cyc = 0;
  int n_busy      = 0;
  int n_ferr      = 0;
  int n_ovr       = 0;

  logic [7:0] exp_q[$];

  uart_rx_frontend #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx_i = v;
    ticks(n);
  endtask

  // Full frame; the stop level is left on the line afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef CEJMU_RX_PARITY_EN
    drive_bit(~^b, CPB);
`endif
    drive_bit(stop_v, CPB);
  endtask

`ifdef CEJMU_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par_v);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(par_v, CPB);
    drive_bit(1'b1, CPB);
  endtask
`endif

  // Start bit plus data bits 0..nbits-1, then half of bit nbits.
  task automatic send_partial(input logic [7:0] b, input int nbits);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive_bit(b[i], CPB);
    drive_bit(b[nbits], CPB / 2);
  endtask

  initial begin
    int b_pop, b_valid, b_busy, b_ferr, b_ovr;
    int w, cnt;
    logic [7:0] pats [4];
    pats = '{8'h00, 8'hFF, 8'h80, 8'h6E};

    rst     = 1'b1;
    ena     = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;

    // Monitor: scoreboard pops, handshake stability and event counting.
    fork
      begin
        logic       prev_hold;
        logic [7:0] prev_data;
        logic [8:0] exp;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        forever begin
          @(negedge clk);
          if (rst) begin
            prev_hold = 1'b0;
          end else begin
            if (prev_hold) begin
              check("hold_valid", 32'(valid_o), 32'd1);
              check("hold_data", 32'(data_o), 32'(prev_data));
            end
            if (valid_o && ready_i) begin
              exp = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
              check("rx_byte", 32'({1'b0, data_o}), 32'(exp));
              n_pop++;
            end
            if (frame_err_o || overrun_o)
              check("flags_exclusive", 32'(frame_err_o & overrun_o), 32'd0);
            if (valid_o)     n_valid_cyc++;
            if (busy_o)      n_busy++;
            if (frame_err_o) n_ferr++;
            if (overrun_o)   n_ovr++;
            prev_hold = valid_o && !ready_i;
            prev_data = data_o;
          end
        end
      end
    join_none

    // Reset state.
    ticks(3);
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_frame_err", 32'(frame_err_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    ticks(5);

    // 0xA5 with ready high: single-cycle valid, busy for the whole frame.
    b_pop = n_pop; b_valid = n_valid_cyc; b_busy = n_busy; b_ferr = n_ferr; b_ovr = n_ovr;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    ticks(4);
    check("a5_pops", 32'(n_pop - b_pop), 32'd1);
    check("a5_valid_cycles", 32'(n_valid_cyc - b_valid), 32'd1);
    check("a5_busy_cycles", 32'(n_busy - b_busy), 32'(BUSY_CYCLES));
    check("a5_frame_err", 32'(n_ferr - b_ferr), 32'd0);
    check("a5_overrun", 32'(n_ovr - b_ovr), 32'd0);
    check("a5_valid_after", 32'(valid_o), 32'd0);

    // Several data patterns back to back.
    b_pop = n_pop; b_ferr = n_ferr;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pats[i]);
      send_frame(pats[i], 1'b1);
    end
    ticks(4);
    check("pats_pops", 32'(n_pop - b_pop), 32'd4);
    check("pats_frame_err", 32'(n_ferr - b_ferr), 32'd0);

    // Two-cycle low glitch: rejected at the start-bit check.
    b_valid = n_valid_cyc; b_ferr = n_ferr; b_ovr = n_ovr;
    rx_i = 1'b0;
    ticks(2);
    rx_i = 1'b1;
    w = 0;
    while (!busy_o && w < 10) begin
      tick();
      w++;
    end
    check("glitch_start_detect", 32'(busy_o), 32'd1);
    cnt = 0;
    while (busy_o && cnt < 20) begin
      tick();
      cnt++;
    end
    check("glitch_busy_clear_cycles", 32'(cnt), 32'(CPB / 2 + 1));
    ticks(4);
    check("glitch_no_valid", 32'(n_valid_cyc - b_valid), 32'd0);
    check("glitch_no_flags", 32'((n_ferr - b_ferr) + (n_ovr - b_ovr)), 32'd0);

    // 0x3C with low stop bit and a held break, then 0x5A.
    b_pop = n_pop; b_ferr = n_ferr; b_ovr = n_ovr;
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 6);
    check("break_one_frame_err", 32'(n_ferr - b_ferr), 32'd1);
    check("break_no_byte", 32'(n_pop - b_pop), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    ticks(4);
    check("after_break_pops", 32'(n_pop - b_pop), 32'd1);
    check("after_break_frame_err", 32'(n_ferr - b_ferr), 32'd1);
    check("after_break_overrun", 32'(n_ovr - b_ovr), 32'd0);

    // Overrun: ready low, 0x11 then 0x22 back to back.
    ready_i = 1'b0;
    b_pop = n_pop; b_ferr = n_ferr; b_ovr = n_ovr;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    ticks(4);
    check("ovr_valid_held", 32'(valid_o), 32'd1);
    check("ovr_data_kept", 32'(data_o), 32'h11);
    check("ovr_pulses", 32'(n_ovr - b_ovr), 32'd1);
    check("ovr_frame_err", 32'(n_ferr - b_ferr), 32'd0);
    ready_i = 1'b1;
    tick();
    check("ovr_valid_cleared", 32'(valid_o), 32'd0);
    check("ovr_pops", 32'(n_pop - b_pop), 32'd1);

    // Reset during data bit 4 of 0x77 while a byte is still pending.
    ready_i = 1'b0;
    send_frame(8'h99, 1'b1);
    ticks(2);
    check("pend_valid", 32'(valid_o), 32'd1);
    send_partial(8'h77, 4);
    check("mid_frame_busy", 32'(busy_o), 32'd1);
    rst  = 1'b1;
    rx_i = 1'b1;
    tick();
    check("midrst_data", 32'(data_o), 32'h00);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_flags", 32'({frame_err_o, overrun_o}), 32'd0);
    rst     = 1'b0;
    ready_i = 1'b1;
    ticks(5);
    b_pop = n_pop;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    ticks(4);
    check("post_rst_pops", 32'(n_pop - b_pop), 32'd1);

    // ena low mid-frame: abort without flags, holding register untouched.
    b_pop = n_pop; b_ferr = n_ferr; b_ovr = n_ovr;
    send_partial(8'h0F, 2);
    ena = 1'b0;
    tick();
    check("ena_abort_busy", 32'(busy_o), 32'd0);
    drive_bit(1'b1, CPB * 8);
    ena = 1'b1;
    ticks(4);
    check("ena_abort_flags", 32'((n_ferr - b_ferr) + (n_ovr - b_ovr)), 32'd0);
    check("ena_abort_no_byte", 32'(n_pop - b_pop), 32'd0);
    check("ena_abort_data_kept", 32'(data_o), 32'h81);

`ifdef CEJMU_RX_PARITY_EN
    // Odd parity: 0x01 with parity 0 is good, with parity 1 is an error.
    b_pop = n_pop; b_ferr = n_ferr;
    exp_q.push_back(8'h01);
    send_frame_par(8'h01, 1'b0);
    ticks(4);
    check("par_good_pops", 32'(n_pop - b_pop), 32'd1);
    check("par_good_no_err", 32'(n_ferr - b_ferr), 32'd0);
    send_frame_par(8'h01, 1'b1);
    ticks(4);
    check("par_bad_frame_err", 32'(n_ferr - b_ferr), 32'd1);
    check("par_bad_no_byte", 32'(n_pop - b_pop), 32'd1);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
